// File: rtl/div_seq_ctrl.sv
// Sequential RV32M divide/remainder unit: restoring divider, one quotient bit
// per cycle, with signed fix-up and RISC-V divide-by-zero / overflow results.

module add_sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] sum,
  output logic        cout
);
  // op=1 subtracts as a + ~b + 1; cout=1 then means a >= b (unsigned)
  logic [32:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, (op ? ~b : b)} + 33'(op);
  end

  assign sum  = full[31:0];
  assign cout = full[32];
endmodule

module div_seq_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter bit          HOLD_RESULT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned LAST_BIT = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               sel_rem_q, sel_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_c;
  logic               is_signed_c;
  logic               div_zero_c;
  logic               overflow_c;
  logic               special_c;
  logic [WIDTH-1:0]   abs_dividend_c;
  logic [WIDTH-1:0]   abs_divisor_c;
  logic [WIDTH-1:0]   special_res_c;
  logic               msb_out_c;
  logic [WIDTH-1:0]   shifted_c;
  logic [WIDTH-1:0]   diff_c;
  logic               cout_c;
  logic               take_c;
  logic [WIDTH-1:0]   quo_fix_c;
  logic [WIDTH-1:0]   rem_fix_c;

  // Operand decode and special-case detection while IDLE
  always_comb begin
    accept_c       = (state_q == S_IDLE) && start && !flush;
    is_signed_c    = !op[0];
    div_zero_c     = (divisor == '0);
    overflow_c     = is_signed_c && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (divisor == '1);
    special_c      = div_zero_c || overflow_c;
    abs_dividend_c = (is_signed_c && dividend[LAST_BIT]) ? (~dividend + WIDTH'(1)) : dividend;
    abs_divisor_c  = (is_signed_c && divisor[LAST_BIT])  ? (~divisor + WIDTH'(1))  : divisor;
    if (div_zero_c) begin
      special_res_c = op[1] ? dividend : '1;
    end else begin
      special_res_c = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // Restoring step: shift one dividend bit into rem, trial-subtract |divisor|
  always_comb begin
    msb_out_c = rem_q[LAST_BIT];
    shifted_c = {rem_q[LAST_BIT-1:0], quo_q[LAST_BIT]};
  end

  add_sub u_add_sub (
    .a    (shifted_c),
    .b    (dvs_q),
    .op   (1'b1),
    .sum  (diff_c),
    .cout (cout_c)
  );

  always_comb begin
    take_c    = cout_c | msb_out_c;
    quo_fix_c = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
    rem_fix_c = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_c) state_d = special_c ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Output decode, registered alongside the state
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath next values
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    result_d  = result_q;
    if (accept_c) begin
      rem_d     = '0;
      quo_d     = abs_dividend_c;
      dvs_d     = abs_divisor_c;
      cnt_d     = '0;
      neg_quo_d = is_signed_c && (dividend[LAST_BIT] ^ divisor[LAST_BIT]);
      neg_rem_d = is_signed_c && dividend[LAST_BIT];
      sel_rem_d = op[1];
      if (special_c) begin
        result_d = special_res_c;
      end
    end else if (!flush) begin
      unique case (state_q)
        S_CALC: begin
          rem_d = take_c ? diff_c : shifted_c;
          quo_d = {quo_q[LAST_BIT-1:0], take_c};
          cnt_d = cnt_q + CNT_W'(1);
        end
        S_FIX:  result_d = sel_rem_q ? rem_fix_c : quo_fix_c;
        S_DONE: if (!HOLD_RESULT) result_d = '0;
        default: ;
      endcase
    end else if (state_q == S_DONE && !HOLD_RESULT) begin
      result_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule
